// File: rtl/burst_ram_queued.sv
// Burst RAM controller model: masked write bursts, queued snapshot read bursts, init calibration.
// Optional periodic refresh stalls are enabled with BURST_RAM_QUEUED_REFRESH_EN.
module burst_ram_queued #(
   parameter string       DataFilePath          = "",
   parameter int unsigned AddressBitWidth       = 4,
   parameter int unsigned DataBitWidth          = 64,
   parameter int unsigned BurstDataCount        = 4,
   parameter int unsigned CyclesBeforeDataValid = 6,
   parameter int unsigned CmdQueueDepth         = 2,
   parameter int unsigned InitCycles            = 8,
   parameter int unsigned RefreshIntervalCycles = 64,
   parameter int unsigned RefreshStallCycles    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd,
   input  logic                        cmd_en,
   input  logic [AddressBitWidth-1:0]  addr,
   input  logic [DataBitWidth-1:0]     wr_data,
   input  logic [DataBitWidth/8-1:0]   data_mask,
   output logic [DataBitWidth-1:0]     rd_data,
   output logic                        rd_data_valid,
   output logic                        init_calib,
   output logic                        busy
);

   localparam int unsigned Depth = 2 ** AddressBitWidth;
   localparam int unsigned Bytes = DataBitWidth / 8;
   localparam int unsigned N     = BurstDataCount;
   localparam int unsigned L     = CyclesBeforeDataValid;
   localparam int unsigned QD    = CmdQueueDepth;
   localparam int unsigned BeatW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PtrW  = (QD > 1) ? $clog2(QD) : 1;
   localparam int unsigned CntW  = $clog2(QD + 1);
   localparam int unsigned RemW  = $clog2(L + 1);
   localparam int unsigned InitW = (InitCycles > 0) ? $clog2(InitCycles + 1) : 1;

   typedef logic [DataBitWidth-1:0] mem_t [Depth];

   function automatic mem_t load_image();
      mem_t img;
      for (int i = 0; i < int'(Depth); i++) img[i] = '0;
      return img;
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(QD - 1)) ? '0 : p + 1'b1;
   endfunction

   logic unused_data_path;
   assign unused_data_path = (DataFilePath != "");

   mem_t mem = load_image();

   // Read queue: each entry is a full burst snapshot plus its remaining latency
   logic [DataBitWidth-1:0] q_data [QD][N];
   logic [RemW-1:0]         q_rem  [QD];
   logic [PtrW-1:0]         rd_ptr, wr_ptr;
   logic [CntW-1:0]         q_cnt;

   logic                       active;
   logic [BeatW-1:0]           beat;
   logic [BeatW-1:0]           wr_left;
   logic [AddressBitWidth-1:0] wr_a;
   logic [InitW-1:0]           init_cnt;

   logic                       acc_rd_c, acc_wr_c, wr_en_c, last_beat_c;
   logic [AddressBitWidth-1:0] wr_a_c;
   logic [DataBitWidth-1:0]    snap_c [N];
   logic                       stall_c, ref_busy_c;
   logic [PtrW-1:0]            cand_ptr_c;
   logic                       cand_ready_c, start_c, init_nxt_c, busy_nxt_c;
   logic [DataBitWidth-1:0]    cand_word_c;
   logic [CntW-1:0]            q_cnt_nxt_c;
   logic [BeatW-1:0]           wr_left_nxt_c;

   // Command decode and burst snapshot
   always_comb begin
      acc_rd_c    = cmd_en && !busy && !cmd;
      acc_wr_c    = cmd_en && !busy && cmd;
      wr_en_c     = acc_wr_c || (wr_left != '0);
      wr_a_c      = acc_wr_c ? addr : wr_a;
      last_beat_c = active && (beat == BeatW'(N - 1));
      for (int i = 0; i < int'(N); i++) snap_c[i] = mem[addr + AddressBitWidth'(i)];
   end

`ifdef BURST_RAM_QUEUED_REFRESH_EN
   localparam int unsigned RefW   = (RefreshIntervalCycles > 1) ? $clog2(RefreshIntervalCycles) : 1;
   localparam int unsigned StallW = (RefreshStallCycles > 0) ? $clog2(RefreshStallCycles + 1) : 1;

   logic [RefW-1:0]   ref_cnt;
   logic              ref_pend;
   logic [StallW-1:0] ref_left;
   logic              grant_c;
   logic [StallW-1:0] ref_left_nxt_c;

   // Refresh is granted only between bursts and never inside a write burst
   always_comb begin
      grant_c = ref_pend && init_calib && (wr_left == '0) && !acc_wr_c
              && !(active && !last_beat_c) && (ref_left == '0);
      ref_left_nxt_c = grant_c ? StallW'(RefreshStallCycles)
                     : ((ref_left != '0) ? ref_left - 1'b1 : '0);
      stall_c    = grant_c || (ref_left > StallW'(1));
      ref_busy_c = (ref_left_nxt_c != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
         ref_left <= '0;
      end else begin
         ref_cnt  <= (ref_cnt == RefW'(RefreshIntervalCycles - 1)) ? '0 : ref_cnt + 1'b1;
         ref_pend <= (ref_cnt == RefW'(RefreshIntervalCycles - 1)) || (ref_pend && !grant_c);
         ref_left <= ref_left_nxt_c;
      end
   end
`else
   logic unused_refresh_cfg;
   assign unused_refresh_cfg = ^{RefreshIntervalCycles, RefreshStallCycles};
   assign stall_c    = 1'b0;
   assign ref_busy_c = 1'b0;
`endif

   // Next burst candidate: queue head when idle, the entry behind it on a last beat,
   // or the incoming read itself when the queue holds nothing for us
   always_comb begin
      cand_ptr_c   = last_beat_c ? ptr_inc(rd_ptr) : rd_ptr;
      cand_ready_c = 1'b0;
      cand_word_c  = snap_c[0];
      if (last_beat_c ? (q_cnt > CntW'(1)) : (q_cnt != '0)) begin
         cand_ready_c = (q_rem[cand_ptr_c] <= RemW'(1));
         cand_word_c  = q_data[cand_ptr_c][0];
      end else begin
         cand_ready_c = acc_rd_c && (L == 1);
      end
      start_c       = (!active || last_beat_c) && cand_ready_c && !stall_c;
      q_cnt_nxt_c   = q_cnt + CntW'(acc_rd_c) - CntW'(last_beat_c);
      wr_left_nxt_c = acc_wr_c ? BeatW'(N - 1)
                    : ((wr_left != '0) ? wr_left - 1'b1 : '0);
      init_nxt_c    = init_calib || (InitCycles == 0)
                    || (InitW'(init_cnt + 1'b1) == InitW'(InitCycles));
      busy_nxt_c    = !init_nxt_c || (wr_left_nxt_c != '0)
                    || (q_cnt_nxt_c == CntW'(QD)) || ref_busy_c;
   end

   // Array and queue storage; contents survive reset
   always_ff @(posedge clk) begin
      for (int s = 0; s < int'(QD); s++)
         if (q_rem[s] != '0) q_rem[s] <= q_rem[s] - 1'b1;
      if (acc_rd_c) begin
         q_rem[wr_ptr] <= RemW'(L - 1);
         for (int i = 0; i < int'(N); i++) q_data[wr_ptr][i] <= snap_c[i];
      end
      if (wr_en_c && !rst)
         for (int b = 0; b < int'(Bytes); b++)
            if (!data_mask[b]) mem[wr_a_c][8*b +: 8] <= wr_data[8*b +: 8];
   end

   // Control state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         q_cnt         <= '0;
         active        <= 1'b0;
         beat          <= '0;
         wr_left       <= '0;
         wr_a          <= '0;
         init_cnt      <= '0;
         init_calib    <= 1'b0;
         busy          <= 1'b1;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
      end else begin
         if (!init_nxt_c) init_cnt <= init_cnt + 1'b1;
         init_calib <= init_nxt_c;
         busy       <= busy_nxt_c;
         wr_left    <= wr_left_nxt_c;
         if (wr_en_c) wr_a <= wr_a_c + 1'b1;
         q_cnt <= q_cnt_nxt_c;
         if (acc_rd_c)    wr_ptr <= ptr_inc(wr_ptr);
         if (last_beat_c) rd_ptr <= ptr_inc(rd_ptr);
         if (active && !last_beat_c) begin
            rd_data       <= q_data[rd_ptr][beat + 1'b1];
            beat          <= beat + 1'b1;
            rd_data_valid <= 1'b1;
         end else if (start_c) begin
            rd_data       <= cand_word_c;
            beat          <= '0;
            active        <= 1'b1;
            rd_data_valid <= 1'b1;
         end else begin
            active        <= 1'b0;
            rd_data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_burst_ram_queued.sv
// Scoreboard bench for burst_ram_queued: bench-side array model and per-beat arrival schedule.
module tb_burst_ram_queued;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned N  = 4;
   localparam int unsigned L  = 6;
   localparam int unsigned QD = 2;
   localparam int unsigned IC = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              cmd = 1'b0;
   logic              cmd_en = 1'b0;
   logic [AW-1:0]     addr = '0;
   logic [DW-1:0]     wr_data = '0;
   logic [DW/8-1:0]   data_mask = '0;
   logic [DW-1:0]     rd_data;
   logic              rd_data_valid;
   logic              init_calib;
   logic              busy;

   burst_ram_queued #(
      .DataFilePath(""), .AddressBitWidth(AW), .DataBitWidth(DW), .BurstDataCount(N),
      .CyclesBeforeDataValid(L), .CmdQueueDepth(QD), .InitCycles(IC),
      .RefreshIntervalCycles(64), .RefreshStallCycles(4)
   ) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
      .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      int            edge_idx;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model [2**AW];
   int            cyc = 0;
   int            last_sched = 0;
   int            rst_edge = -1;
   int            n_checks = 0;
   int            n_pass = 0;
   logic [DW-1:0] hold_val = '0;
   bit            mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
   endtask

   // Beats are compared at the negative edge following the edge they were scheduled for
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (cyc == rst_edge) begin
            hold_val = '0;
            while (exp_q.size() != 0 && exp_q[exp_q.size()-1].edge_idx >= rst_edge)
               void'(exp_q.pop_back());
         end
         if (exp_q.size() != 0 && exp_q[0].edge_idx == cyc) begin
            e = exp_q.pop_front();
            check("rd_valid", DW'(rd_data_valid), DW'(1));
            check("rd_data", rd_data, e.data);
            hold_val = e.data;
         end else begin
            check("rd_idle_valid", DW'(rd_data_valid), DW'(0));
            check("rd_hold", rd_data, hold_val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      if (busy) check("busy_timeout", DW'(busy), DW'(0));
   endtask

   task automatic do_read(input logic [AW-1:0] a, output int t);
      int first;
      wait_ready();
      cmd_en = 1'b1; cmd = 1'b0; addr = a;
      tick();
      t = cyc;
      cmd_en = 1'b0;
      first = (t + int'(L) - 1 > last_sched + 1) ? t + int'(L) - 1 : last_sched + 1;
      for (int i = 0; i < int'(N); i++)
         exp_q.push_back('{data: model[a + AW'(i)], edge_idx: first + i});
      last_sched = first + int'(N) - 1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [N*DW-1:0] d,
                           input logic [N*DW/8-1:0] m);
      logic [AW-1:0] w;
      wait_ready();
      cmd_en = 1'b1; cmd = 1'b1; addr = a;
      for (int i = 0; i < int'(N); i++) begin
         wr_data   = d[i*DW +: DW];
         data_mask = m[i*(DW/8) +: DW/8];
         if (i > 0) begin
            // a read command during write beats must be ignored
            cmd = 1'b0; addr = AW'($urandom);
            check("wr_beat_busy", DW'(busy), DW'(1));
         end
         tick();
         w = a + AW'(i);
         for (int b = 0; b < int'(DW/8); b++)
            if (!m[i*(DW/8) + b]) model[w][8*b +: 8] = d[i*DW + 8*b +: 8];
      end
      cmd_en = 1'b0;
   endtask

   task automatic check_init();
      for (int i = 0; i < int'(IC); i++) begin
         check("init_calib_low", DW'(init_calib), DW'(0));
         check("init_busy_high", DW'(busy), DW'(1));
         tick();
      end
      check("init_calib_high", DW'(init_calib), DW'(1));
      check("init_busy_low", DW'(busy), DW'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst_edge = cyc;
      mon_en = 1'b1;
      last_sched = 0;
      rst = 1'b0;
      check("rst_rd_data", rd_data, DW'(0));
      check("rst_rd_valid", DW'(rd_data_valid), DW'(0));
      check_init();
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      tick();
      tick();
   endtask

   initial begin
      int t, t2;
      logic [N*DW-1:0]     d;
      logic [N*DW/8-1:0]   m;
      for (int i = 0; i < (2**AW); i++) model[i] = '0;

      do_reset();

      // Plain burst write then read back
      do_write(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, '0);
      do_read(4'd2, t);
      drain();

      // Byte masking: low four bytes of word 0 keep their old value
      do_write(4'd0, '0, '0);
      do_write(4'd0, {192'h0, 64'hFFFF_FFFF_FFFF_FFFF}, {8'hFF, 8'hFF, 8'hFF, 8'h0F});
      do_read(4'd0, t);
      drain();

      // Two queued reads: full-queue busy window and back-to-back beats
      do_read(4'd0, t);
      do_read(4'd4, t2);
      check("q_second_accept", DW'(t2), DW'(t + 1));
      while (cyc <= t + 8) begin
         check("q_full_busy", DW'(busy), DW'(1));
         tick();
      end
      check("q_full_clear", DW'(busy), DW'(0));
      drain();

      // Address wrap-around
      do_write(4'd14, {64'h0000_0000_0000_0E01, 64'h0000_0000_0000_0E00,
                       64'h0000_0000_0000_0E0F, 64'h0000_0000_0000_0E0E}, '0);
      do_read(4'd14, t);
      drain();

      // Snapshot: a later write cannot alter an accepted read
      do_read(4'd4, t);
      do_write(4'd4, {4{64'hAAAA_AAAA_AAAA_AAAA}}, '0);
      drain();

      // Mixed random traffic
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int j = 0; j < int'(N*DW/32); j++) d[j*32 +: 32] = $urandom;
            m = $urandom;
            do_write(AW'($urandom), d, m);
         end else begin
            do_read(AW'($urandom), t);
         end
      end
      drain();

      // Reset while beat 2 of a read is on the output
      do_read(4'd2, t);
      while (cyc < t + int'(L) + 1) tick();
      do_reset();
      do_read(4'd2, t);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
